// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Op-code encoding and FSM state type shared by the sequential ALU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [2:0] OP_ILL = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_NOT = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_seq_if.sv
// ============================================================================
// Module : alu_seq_if
// Brief  : Operand/result handshake bundle; master drives operands and
//          out_ready, slave is the ALU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_seq_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_fun;
  logic [WIDTH-1:0] operA;
  logic [WIDTH-1:0] operB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, alu_fun, operA, operB, out_ready,
    input  in_ready, out_valid, result, carry, zero, negative
  );

  modport slave (
    input  in_valid, alu_fun, operA, operB, out_ready,
    output in_ready, out_valid, result, carry, zero, negative
  );

endinterface

`default_nettype wire

// File: rtl/alu_mul_iter.sv
// ============================================================================
// Module : alu_mul_iter
// Brief  : Unsigned shift-add multiplier, one partial product per cycle.
//          Only built when ALU_SEQ_MUL_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef ALU_SEQ_MUL_EN
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  wire logic               clk,
  input  wire logic               reset_n,
  input  wire logic               start,
  input  wire logic [WIDTH-1:0]   op_a,
  input  wire logic [WIDTH-1:0]   op_b,
  output logic                    done,
  output logic [2*WIDTH-1:0]      product
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  logic                 busy_q, busy_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   acc_step;

  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, op_a};
      mplier_d = op_b;
      acc_d    = '0;
    end else if (busy_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  // The final partial product is presented combinationally so the caller
  // can capture it on the same edge that retires the last iteration.
  assign done    = busy_q && (cnt_q == LAST);
  assign product = acc_step;

endmodule
`endif

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module : alu_seq
// Brief  : Registered, valid/ready handshaked ALU with a single output slot.
//          Define ALU_SEQ_MUL_EN to enable the iterative multiply on op 7.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic  clk,
  input  wire logic  reset_n,
  alu_seq_if.slave   bus
);

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               negative_q, negative_d;

  logic [WIDTH:0]     ext_a, ext_b, alu_ext;
  logic               alu_neg;
  logic               in_rdy;
  logic               accept;
  logic               is_mul;
  logic               mul_done;
  logic [WIDTH-1:0]   mul_res;
  logic               mul_carry;
  logic               mul_zero;

  assign ext_a = {1'b0, bus.operA};
  assign ext_b = {1'b0, bus.operB};

  // B is the first operand throughout, matching the combinational ALU.
  always_comb begin
    alu_ext = '0;
    alu_neg = 1'b0;
    case (bus.alu_fun)
      OP_ADD: alu_ext = ext_b + ext_a;
      OP_SUB: begin
        alu_ext = ext_b - ext_a;
        alu_neg = (bus.operB < bus.operA);
      end
      OP_NOT: alu_ext = {1'b0, ~bus.operB};
      OP_AND: alu_ext = ext_b & ext_a;
      OP_OR:  alu_ext = ext_b | ext_a;
      OP_XOR: alu_ext = ext_b ^ ext_a;
      default: alu_ext = '0;
    endcase
  end

  assign in_rdy       = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && in_rdy;
  assign bus.in_ready = in_rdy;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] product;

  assign is_mul = (bus.alu_fun == OP_MUL);

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (accept && is_mul),
    .op_a    (bus.operA),
    .op_b    (bus.operB),
    .done    (mul_done),
    .product (product)
  );

  assign mul_res   = product[WIDTH-1:0];
  assign mul_carry = |product[2*WIDTH-1:WIDTH];
  assign mul_zero  = (product == '0);
`else
  assign is_mul    = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_res   = '0;
  assign mul_carry = 1'b0;
  assign mul_zero  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    negative_d  = negative_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_d = BUSY;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_ext[WIDTH-1:0];
            carry_d     = alu_ext[WIDTH];
            zero_d      = (alu_ext == '0);
            negative_d  = alu_neg;
          end
        end
      end
      BUSY: begin
        if (mul_done) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          result_d    = mul_res;
          carry_d     = mul_carry;
          zero_d      = mul_zero;
          negative_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      negative_q  <= negative_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = negative_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module : tb_alu_seq
// Brief  : Scoreboard bench for alu_seq: directed corner cases then random
//          traffic with random backpressure. Honours ALU_SEQ_MUL_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        n;
    int          lat;
    int          first;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   rand_rdy = 0;
  bit   fresh = 1;
  exp_t sb[$];

  alu_seq_if #(.WIDTH(32)) bus ();

  alu_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference behaviour from plain unsigned arithmetic on 64-bit integers.
  function automatic exp_t model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    exp_t e;
    longint unsigned ua, ub, t;
    ua = longint'(a);
    ub = longint'(b);
    e.res = 32'd0; e.c = 1'b0; e.z = 1'b1; e.n = 1'b0; e.lat = 1; e.first = 0;
    case (op)
      3'd1: begin
        t = ub + ua;
        e.res = 32'(t); e.c = (t >> 32) != 0; e.z = (t == 0);
      end
      3'd2: begin
        e.res = 32'(ub - ua); e.c = (ub < ua); e.n = (ub < ua); e.z = (ub == ua);
      end
      3'd3: begin e.res = ~b;    e.z = (e.res == 0); end
      3'd4: begin e.res = a & b; e.z = (e.res == 0); end
      3'd5: begin e.res = a | b; e.z = (e.res == 0); end
      3'd6: begin e.res = a ^ b; e.z = (e.res == 0); end
`ifdef ALU_SEQ_MUL_EN
      3'd7: begin
        t = ua * ub;
        e.res = 32'(t); e.c = (t >> 32) != 0; e.z = (t == 0); e.lat = 33;
      end
`endif
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom());
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Called at negedge+1 once in_ready is known: transfer occurs at the next edge.
  task automatic push_exp(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    exp_t e;
    e = model(op, a, b);
    e.first = cyc + e.lat;
    sb.push_back(e);
  endtask

  task automatic send(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    int n;
    bus.in_valid = 1'b1;
    bus.alu_fun  = op;
    bus.operA    = a;
    bus.operB    = b;
    #1;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      tick(); #1; n++;
    end
    chk("accept_in_ready", {63'd0, bus.in_ready}, 64'd1);
    if (bus.in_ready) push_exp(op, a, b);
    tick();
    bus.in_valid = 1'b0;
    bus.operA    = 32'($urandom());
    bus.operB    = 32'($urandom());
  endtask

  task automatic drain();
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      tick(); n++;
    end
    chk("drain_queue_empty", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compare the output slot against the queue head on every valid cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && bus.out_valid) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_output: got result %0h with no pending request", bus.result);
        end else begin
          e = sb[0];
          if (fresh) begin
            chk("latency_cycle", 64'(cyc), 64'(e.first));
            fresh = 0;
          end
          chk("result",   {32'd0, bus.result},   {32'd0, e.res});
          chk("carry",    {63'd0, bus.carry},    {63'd0, e.c});
          chk("zero",     {63'd0, bus.zero},     {63'd0, e.z});
          chk("negative", {63'd0, bus.negative}, {63'd0, e.n});
          if (bus.out_ready) begin
            void'(sb.pop_front());
            fresh = 1;
          end
        end
      end else begin
        fresh = 1;
      end
    end
  end

  initial begin : stim
    int c0;
    logic [2:0] op;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alu_fun   = 3'd0;
    bus.operA     = 32'd0;
    bus.operB     = 32'd0;
    bus.out_ready = 1'b1;

    repeat (3) tick();
    #1;
    chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("reset_result",    {32'd0, bus.result},    64'd0);
    chk("reset_flags",     {61'd0, bus.carry, bus.zero, bus.negative}, 64'd0);
    reset_n = 1'b1;
    tick(); #1;
    chk("post_reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    tick();

    send(3'd1, 32'h0000_0001, 32'hFFFF_FFFF);
    send(3'd2, 32'd5, 32'd3);
    send(3'd2, 32'd5, 32'd5);
    drain();

    c0 = cyc;
    for (int i = 0; i < 4; i++) send(3'd6, rnd_op(), rnd_op());
    chk("xor_throughput_cycles", 64'(cyc - c0), 64'd4);
    drain();

    // Stall the slot for three cycles with a request waiting.
    bus.out_ready = 1'b0;
    send(3'd6, 32'hA5A5_0F0F, 32'h0FF0_1234);
    bus.in_valid = 1'b1; bus.alu_fun = 3'd6; bus.operA = 32'h1111_2222; bus.operB = 32'h3333_4444;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", {63'd0, bus.in_ready}, 64'd1);
    if (bus.in_ready) push_exp(3'd6, 32'h1111_2222, 32'h3333_4444);
    tick();
    bus.in_valid = 1'b0;
    drain();

    send(3'd7, 32'h0001_0000, 32'h0001_0000);
`ifdef ALU_SEQ_MUL_EN
    for (int i = 0; i < 30; i++) begin
      #1;
      chk("busy_in_ready", {63'd0, bus.in_ready}, 64'd0);
      tick();
    end
`endif
    drain();

    // Reset partway through a multiply with the output slot held.
    bus.out_ready = 1'b0;
    send(3'd7, 32'h0001_0000, 32'h0001_0000);
    repeat (10) tick();
    #3;
    reset_n = 1'b0;
    sb.delete();
    #1;
    chk("midreset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("midreset_result",    {32'd0, bus.result},    64'd0);
    chk("midreset_flags",     {61'd0, bus.carry, bus.zero, bus.negative}, 64'd0);
    bus.out_ready = 1'b1;
    tick(); tick();
    #3;
    reset_n = 1'b1;
    tick(); #1;
    chk("release_after_reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    tick();
    send(3'd1, 32'd2, 32'd2);
    send(3'd0, 32'h1234, 32'h1234);
    drain();

    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7));
      send(op, rnd_op(), rnd_op());
    end
    rand_rdy = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
